// File: rtl/jk_seq_decoder.sv
// Recovers encoder input bits from an observed {FA,FB} state stream, packs them
// into BYTE_W-bit words, and counts illegal state transitions.
module jk_seq_decoder #(
  parameter int BYTE_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [1:0]        st,
  output logic              x_out,
  output logic              x_valid,
  output logic              err,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid
);

  localparam int CNT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {
    TR_DECODE  = 2'd0,
    TR_SILENT  = 2'd1,
    TR_ILLEGAL = 2'd2
  } tr_kind_e;

  logic [1:0]        prev_st_q, prev_st_d;
  logic              prev_vld_q, prev_vld_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              x_out_q, x_out_d;
  logic              x_valid_q, x_valid_d;
  logic              err_q, err_d;
  logic              err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [BYTE_W-1:0] byte_out_q, byte_out_d;
  logic              byte_valid_q, byte_valid_d;

  tr_kind_e          tr_kind;
  logic              dec_x;
  logic [BYTE_W-1:0] shifted;

  // Inverse of the encoder transition table, indexed by {from, to}.
  always_comb begin
    tr_kind = TR_ILLEGAL;
    dec_x   = 1'b0;
    case ({prev_st_q, st})
      4'b00_10: begin tr_kind = TR_DECODE; dec_x = 1'b0; end
      4'b00_00: begin tr_kind = TR_DECODE; dec_x = 1'b1; end
      4'b10_11: begin tr_kind = TR_DECODE; dec_x = 1'b0; end
      4'b10_10: begin tr_kind = TR_DECODE; dec_x = 1'b1; end
      4'b11_01: begin tr_kind = TR_DECODE; dec_x = 1'b0; end
      4'b11_11: begin tr_kind = TR_DECODE; dec_x = 1'b1; end
      4'b01_00: begin tr_kind = TR_SILENT; dec_x = 1'b0; end
      default:  begin tr_kind = TR_ILLEGAL; dec_x = 1'b0; end
    endcase
  end

  assign shifted = {shreg_q[BYTE_W-2:0], dec_x};

  always_comb begin
    prev_st_d    = prev_st_q;
    prev_vld_d   = prev_vld_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    x_out_d      = x_out_q;
    x_valid_d    = 1'b0;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;

    if (clr) begin
      // Clear drops the decoding context but keeps the last completed word.
      prev_vld_d   = 1'b0;
      shreg_d      = '0;
      bit_cnt_d    = '0;
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end else if (en) begin
      prev_st_d  = st;
      prev_vld_d = 1'b1;
      if (prev_vld_q) begin
        case (tr_kind)
          TR_DECODE: begin
            x_out_d   = dec_x;
            x_valid_d = 1'b1;
            shreg_d   = shifted;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d    = '0;
              byte_out_d   = shifted;
              byte_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          TR_ILLEGAL: begin
            err_d        = 1'b1;
            err_sticky_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_st_q    <= '0;
      prev_vld_q   <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      x_out_q      <= 1'b0;
      x_valid_q    <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      prev_st_q    <= prev_st_d;
      prev_vld_q   <= prev_vld_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      x_out_q      <= x_out_d;
      x_valid_q    <= x_valid_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  assign x_out      = x_out_q;
  assign x_valid    = x_valid_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;

endmodule

// File: tb/tb_jk_seq_decoder.sv
// Bench for jk_seq_decoder: vector table, directed multi-cycle sequences and
// randomized traffic checked against an encoder-level reference model.
module tb_jk_seq_decoder;

  localparam int BYTE_W = 8;
  localparam int ERR_W  = 4;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic              clk;
  logic              rst;
  logic              en;
  logic              clr;
  logic [1:0]        st;
  logic              x_out;
  logic              x_valid;
  logic              err;
  logic              err_sticky;
  logic [ERR_W-1:0]  err_cnt;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;

  jk_seq_decoder #(.BYTE_W(BYTE_W), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .st         (st),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .err        (err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .byte_out   (byte_out),
    .byte_valid (byte_valid)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]        m_prev;
  logic              m_vld;
  logic              m_bit_q[$];
  int                m_errcnt;
  logic              m_sticky;
  logic [BYTE_W-1:0] m_byte;
  logic [BYTE_W-1:0] exp_q[$];
  logic              exp_xv, exp_x, exp_err, exp_bv;

  // Forward encoder: state reached from s when input bit x is applied.
  function automatic logic [1:0] enc_next(input logic [1:0] s, input logic x);
    case (s)
      2'b00:   return x ? 2'b00 : 2'b10;
      2'b10:   return x ? 2'b10 : 2'b11;
      2'b11:   return x ? 2'b11 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_prev = 2'b00;
    m_vld = 1'b0;
    m_bit_q.delete();
    m_errcnt = 0;
    m_sticky = 1'b0;
    m_byte = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic e, input logic c, input logic [1:0] s);
    int   hits;
    logic cand;
    exp_xv = 1'b0; exp_x = 1'b0; exp_err = 1'b0; exp_bv = 1'b0;
    hits = 0; cand = 1'b0;
    if (c) begin
      m_vld = 1'b0;
      m_bit_q.delete();
      m_errcnt = 0;
      m_sticky = 1'b0;
    end else if (e) begin
      if (m_vld) begin
        for (int b = 0; b < 2; b++) begin
          if (enc_next(m_prev, 1'(b)) == s) begin
            hits++;
            cand = 1'(b);
          end
        end
        if (hits == 1) begin
          exp_xv = 1'b1;
          exp_x  = cand;
          m_bit_q.push_back(cand);
          if (m_bit_q.size() == BYTE_W) begin
            m_byte = '0;
            foreach (m_bit_q[i]) m_byte = {m_byte[BYTE_W-2:0], m_bit_q[i]};
            m_bit_q.delete();
            exp_q.push_back(m_byte);
            exp_bv = 1'b1;
          end
        end else if (hits == 0) begin
          exp_err  = 1'b1;
          m_sticky = 1'b1;
          if (m_errcnt < ERR_MAX) m_errcnt++;
        end
      end
      m_prev = s;
      m_vld  = 1'b1;
    end
  endtask

  task automatic check_model();
    logic [BYTE_W-1:0] w;
    check("x_valid", 32'(x_valid), 32'(exp_xv));
    if (exp_xv) check("x_out", 32'(x_out), 32'(exp_x));
    check("err", 32'(err), 32'(exp_err));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
    check("byte_valid", 32'(byte_valid), 32'(exp_bv));
    if (byte_valid && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("byte_word", 32'(byte_out), 32'(w));
    end
    check("byte_out", 32'(byte_out), 32'(m_byte));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic e, input logic c, input logic [1:0] s);
    @(negedge clk);
    en = e; clr = c; st = s;
    @(posedge clk);
    #1;
  endtask

  task automatic mstep(input logic e, input logic c, input logic [1:0] s);
    step(e, c, s);
    model_step(e, c, s);
    check_model();
  endtask

  // Reset asserted away from any clock edge so the async path is exercised.
  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; clr = 1'b0; st = 2'b00;
    #2 rst = 1'b0;
    #1;
    check("rst_x_out", 32'(x_out), 32'd0);
    check("rst_x_valid", 32'(x_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic       clr;
    logic [1:0] st;
    logic       xv;
    logic       x;
    logic       err;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[12];

  int xv_count;
  int bv_count;
  int bv_at;
  logic [1:0] s_r;

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; st = 2'b00;
    model_reset();

    //           en    clr   st     xv    x     err   cnt
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[3]  = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[6]  = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 4'd1};
    vecs[9]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[10] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 4'd2};
    vecs[11] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd2};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].st);
      check($sformatf("vec%0d_xv", i), 32'(x_valid), 32'(vecs[i].xv));
      if (vecs[i].xv) check($sformatf("vec%0d_x", i), 32'(x_out), 32'(vecs[i].x));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("vec%0d_cnt", i), 32'(err_cnt), 32'(vecs[i].cnt));
    end
    check("vec_sticky", 32'(err_sticky), 32'd1);

    // Eight decoded ones after priming: byte with the 8th bit.
    do_reset();
    xv_count = 0; bv_count = 0; bv_at = -1;
    mstep(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      mstep(1'b1, 1'b0, 2'b00);
      if (x_valid) xv_count++;
      if (byte_valid) begin bv_count++; bv_at = xv_count; end
    end
    check("ones_xv_count", 32'(xv_count), 32'd8);
    check("ones_bv_count", 32'(bv_count), 32'd1);
    check("ones_bv_at", 32'(bv_at), 32'd8);
    check("ones_byte", 32'(byte_out), 32'hFF);

    // Saturating illegal-transition counter, then clear and re-prime.
    mstep(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) mstep(1'b1, 1'b0, (i % 2 == 0) ? 2'b11 : 2'b00);
    check("sat_err_cnt", 32'(err_cnt), 32'd15);
    mstep(1'b1, 1'b1, 2'b10);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);
    check("clr_sticky", 32'(err_sticky), 32'd0);
    check("clr_byte_hold", 32'(byte_out), 32'hFF);
    mstep(1'b1, 1'b0, 2'b11);
    check("clr_prime_err", 32'(err), 32'd0);
    check("clr_prime_xv", 32'(x_valid), 32'd0);

    // Three bits, five disabled cycles with toggling st, then five more bits.
    do_reset();
    mstep(1'b1, 1'b0, 2'b00);
    mstep(1'b1, 1'b0, 2'b10);
    mstep(1'b1, 1'b0, 2'b11);
    mstep(1'b1, 1'b0, 2'b11);
    bv_count = 0; xv_count = 0;
    for (int i = 0; i < 5; i++) begin
      mstep(1'b0, 1'b0, 2'(i));
      if (x_valid || err || byte_valid) xv_count++;
    end
    check("hold_no_pulse", 32'(xv_count), 32'd0);
    mstep(1'b1, 1'b0, 2'b01);
    mstep(1'b1, 1'b0, 2'b00);
    mstep(1'b1, 1'b0, 2'b00);
    mstep(1'b1, 1'b0, 2'b10);
    check("hold_not_yet", 32'(byte_valid), 32'd0);
    mstep(1'b1, 1'b0, 2'b10);
    mstep(1'b1, 1'b0, 2'b11);
    check("hold_bv", 32'(byte_valid), 32'd1);
    check("hold_byte", 32'(byte_out), 32'h2A);

    // Reset mid-word discards partial bits.
    mstep(1'b1, 1'b0, 2'b11);
    mstep(1'b1, 1'b0, 2'b11);
    mstep(1'b1, 1'b0, 2'b11);
    do_reset();
    bv_count = 0;
    mstep(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      mstep(1'b1, 1'b0, 2'b00);
      if (byte_valid) bv_count++;
    end
    check("midrst_no_bv", 32'(bv_count), 32'd0);

    // Randomized traffic, mostly legal encoder walks with injected faults.
    for (int chunk = 0; chunk < 4; chunk++) begin
      do_reset();
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 99) < 80) s_r = enc_next(m_prev, 1'($urandom_range(0, 1)));
        else s_r = 2'($urandom_range(0, 3));
        mstep(1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 99) < 3), s_r);
      end
    end
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_seq_decoder.md
JK_SEQ_DECODER -- requirements
Module: jk_seq_decoder

Interface
REQ-001 The block SHALL have parameter BYTE_W, default 8: the width of the assembled decoded word.
REQ-002 The block SHALL have parameter ERR_W, default 4: the width of the saturating illegal-transition counter.
REQ-003 clk  input  1  The block SHALL have one clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  The block SHALL use an asynchronous, active-low reset.
REQ-005 en  input  1  Sample enable: st is consumed only on an edge where en=1.
REQ-006 clr  input  1  Synchronous clear of the decoding context.
REQ-007 st  input  2  Observed encoder state {FA,FB}.
REQ-008 x_out  output  1  Recovered encoder input bit; meaningful only while x_valid=1.
REQ-009 x_valid  output  1  One-cycle pulse: x_out holds a decoded bit.
REQ-010 err  output  1  One-cycle pulse: an illegal transition was observed.
REQ-011 err_sticky  output  1  Set by any err pulse; held until clr or reset.
REQ-012 err_cnt  output  ERR_W  Saturating count of illegal transitions.
REQ-013 byte_out  output  BYTE_W  Last completed word of decoded bits.
REQ-014 byte_valid  output  1  One-cycle pulse: byte_out was updated.

Function
REQ-015 Internal state SHALL comprise prev_st[1:0], prev_vld, shreg[BYTE_W-1:0], and a bit counter of width ceil(log2(BYTE_W)).
REQ-016 The decoder SHALL invert the encoder transitions (from -> to : x) exactly as follows: 00->10:0, 00->00:1, 10->11:0, 10->10:1, 11->01:0, 11->11:1.
REQ-017 The transition 01->00 SHALL be legal but non-decodable: x_valid=0 and err=0.
REQ-018 Every other (from, to) pair SHALL be illegal: err=1 for one cycle, x_valid=0, err_sticky set, and err_cnt incremented, saturating at 2^ERR_W-1.
REQ-019 On an edge with en=1, clr=0, and prev_vld=0, the block SHALL only load prev_st<=st and prev_vld<=1, with no pulses (priming).
REQ-020 On an edge with en=1, clr=0, and prev_vld=1, the block SHALL evaluate (prev_st, st) per REQ-016 to REQ-018 and then load prev_st<=st; this also applies after an illegal transition (resynchronisation).
REQ-021 Latency SHALL be 1 clock: x_out, x_valid, and err are registered and valid the cycle after the edge that sampled the "to" state.
REQ-022 For each decoded bit, the block SHALL apply shreg<={shreg[BYTE_W-2:0],x} (first decoded bit ends up in the MSB) and increment the counter.
REQ-023 When the BYTE_W-th bit is decoded, the block SHALL load byte_out with the completed word on the same edge, pulse byte_valid, and wrap the counter to 0.
REQ-024 Non-decodable and illegal transitions SHALL NOT shift shreg or advance the counter.
REQ-025 When en=0, all state SHALL hold and x_valid, err, and byte_valid SHALL be 0.
REQ-026 clr=1 SHALL take priority over en on the same edge: the sample is ignored; prev_vld, shreg, the counter, err_sticky, and err_cnt are cleared; pulses are 0; byte_out holds.

Reset
REQ-027 While rst=0, all outputs and internal registers SHALL be 0 immediately, regardless of clk.
REQ-028 After rst deasserts, the first enabled sample SHALL be a priming sample (prev_vld=0).
REQ-029 Asserting reset mid-word SHALL discard partial bits; no byte_valid pulse SHALL follow.

Verification
REQ-030 Reset, then st=00,10,11,11,01,00 with en=1 -> x_valid pulses carrying 0,0,1,0; no pulse for 01->00; err_cnt=0.
REQ-031 Prime with 00, then eight further samples of 00 -> eight x_valid pulses with x_out=1; byte_out=8'hFF and byte_valid pulses once, coincident with the 8th x_valid.
REQ-032 Sequence 00,01,00,11 -> err pulses for 00->01 and 00->11 only; 01->00 is silent; err_sticky=1; err_cnt=2.
REQ-033 Twenty consecutive 00->11->00... illegal transitions -> err_cnt=15 (saturated); clr -> err_cnt=0, err_sticky=0, and the next sample only primes.
REQ-034 Three bits decoded, then en=0 for 5 cycles with st toggling -> no pulses and the counter holds; resume -> byte completes after 5 more decoded bits.
REQ-035 clr and en high on the same edge with a decodable st -> no x_valid; the following sample only primes.
